// File: rtl/bit_serial_add_sched_if.sv
// Request/response bundle for the shared bit-serial adder.
//   master : requester/consumer side (drives jobs and RSP_READY)
//   slave  : the adder scheduler (drives REQ_READY and the response)
// Requester i's operands sit at REQ_A/REQ_B[i*WIDTH +: WIDTH].
interface bit_serial_add_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       REQ_VALID;
    logic [NREQ-1:0]       REQ_READY;
    logic [NREQ*WIDTH-1:0] REQ_A;
    logic [NREQ*WIDTH-1:0] REQ_B;
    logic [NREQ-1:0]       REQ_CIN;
    logic                  RSP_VALID;
    logic                  RSP_READY;
    logic [IDW-1:0]        RSP_ID;
    logic [WIDTH-1:0]      RSP_SUM;
    logic                  RSP_COUT;

    modport master (
        output REQ_VALID, REQ_A, REQ_B, REQ_CIN, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_ID, RSP_SUM, RSP_COUT
    );

    modport slave (
        input  REQ_VALID, REQ_A, REQ_B, REQ_CIN, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_ID, RSP_SUM, RSP_COUT
    );
endinterface

// File: rtl/bit_serial_add_sched.sv
// Shared bit-serial adder: NREQ requesters arbitrate round-robin for a single
// full-adder cell with a registered carry. An accepted job computes A+B+CIN
// LSB-first over WIDTH cycles and is returned with the owner's ID.
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : request/response bundle (slave side)
//   BUSY     : a job is in flight (SHIFT or DONE)
module bit_serial_add_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    bit_serial_add_sched_if.slave  bus,
    output logic                   BUSY
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   id;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             rsp_valid;
    logic [WIDTH-1:0] sa, sb, sum;

    logic             found;
    logic [IDW-1:0]   grant, cand, rr_nxt;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_cin;
    logic             s_bit, c_nxt;

    // Round-robin search starting at rr_ptr; the first valid requester wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!found && bus.REQ_VALID[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_a   = bus.REQ_A[i*WIDTH +: WIDTH];
                sel_b   = bus.REQ_B[i*WIDTH +: WIDTH];
                sel_cin = bus.REQ_CIN[i];
            end
        end
    end

    // Ready is combinational so a requester is accepted in the cycle it wins.
    always_comb begin
        bus.REQ_READY = '0;
        if (state == IDLE && found && !RST)
            bus.REQ_READY[grant] = 1'b1;
    end

    assign rr_nxt = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

    // Full-adder cell on the current LSBs.
    assign s_bit = sa[0] ^ sb[0] ^ carry;
    assign c_nxt = (sa[0] & sb[0]) | ((sa[0] ^ sb[0]) & carry);

    assign bus.RSP_VALID = rsp_valid;
    assign bus.RSP_ID    = id;
    assign bus.RSP_SUM   = sum;
    assign bus.RSP_COUT  = carry;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id        <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            sa        <= '0;
            sb        <= '0;
            sum       <= '0;
            rsp_valid <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        sa     <= sel_a;
                        sb     <= sel_b;
                        carry  <= sel_cin;
                        id     <= grant;
                        cnt    <= '0;
                        rr_ptr <= rr_nxt;
                        BUSY   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry <= c_nxt;
                    sa    <= {1'b0, sa[WIDTH-1:1]};
                    sb    <= {1'b0, sb[WIDTH-1:1]};
                    // Sum bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
                    sum   <= {s_bit, sum[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.RSP_READY) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        BUSY      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_add_sched.sv
// Bench for bit_serial_add_sched (NREQ=4, WIDTH=16). Expected results come
// from integer addition of the bench's own operands and a round-robin model,
// queued at accept and popped when the response appears.
module tb_bit_serial_add_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 16;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        cout;
    } exp_t;

    logic clk;
    logic rst;
    logic busy;

    bit_serial_add_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();

    bit_serial_add_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave),
        .BUSY(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          rr_m  = 0;
    logic [15:0] a_m[NREQ];
    logic [15:0] b_m[NREQ];
    logic        c_m[NREQ];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    function automatic int model_grant(input logic [3:0] v, input int rr);
        for (int k = 0; k < NREQ; k++)
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        return -1;
    endfunction

    function automatic exp_t model_result(input int i);
        exp_t        e;
        logic [16:0] t;
        t      = {1'b0, a_m[i]} + {1'b0, b_m[i]} + 17'(c_m[i]);
        e.id   = 2'(i);
        e.sum  = t[15:0];
        e.cout = t[16];
        return e;
    endfunction

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
        a_m[i] = a;
        b_m[i] = b;
        c_m[i] = c;
        bus.REQ_A[i*WIDTH +: WIDTH] = a;
        bus.REQ_B[i*WIDTH +: WIDTH] = b;
        bus.REQ_CIN[i] = c;
        bus.REQ_VALID[i] = 1'b1;
    endtask

    // Returns just after the accepting edge; rdy is REQ_READY in the accept cycle.
    task automatic wait_accept(input int budget, output int g, output logic [3:0] rdy, output bit ok);
        ok = 0; g = -1; rdy = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (|(bus.REQ_READY & bus.REQ_VALID)) begin
                rdy = bus.REQ_READY;
                for (int i = 0; i < NREQ; i++) if (rdy[i]) g = i;
                ok = 1;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    // Returns on the negedge where RSP_VALID is first seen high.
    task automatic wait_rsp(input int budget, output int cyc, output bit ok, output bit leak);
        ok = 0; leak = 0; cyc = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (bus.REQ_READY !== 4'b0000) leak = 1;
            if (bus.RSP_VALID === 1'b1) begin
                cyc = c; ok = 1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        rr_m = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.REQ_VALID = 4'hF;
        @(negedge clk);
        n_cmp++; if (bus.RSP_VALID !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", bus.RSP_VALID); end
        n_cmp++; if (bus.RSP_SUM !== 16'h0) begin n_err++; $display("FAIL reset_rsp_sum: got %h want 0000", bus.RSP_SUM); end
        n_cmp++; if (bus.RSP_ID !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id: got %0d want 0", bus.RSP_ID); end
        n_cmp++; if (bus.RSP_COUT !== 1'b0) begin n_err++; $display("FAIL reset_rsp_cout: got %b want 0", bus.RSP_COUT); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (bus.REQ_READY !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", bus.REQ_READY); end
        @(posedge clk); #1;
        bus.REQ_VALID = '0;
        rst = 1'b0;
        rr_m = 0;
    endtask

    // Runs one job from requester i alone (other valids already low) with RSP_READY=1.
    task automatic run_single(input string nm, input int i, input logic [15:0] a, input logic [15:0] b, input logic c, input bit check_lat);
        int g, cyc, eg; logic [3:0] rdy; bit ok, leak; exp_t e;
        set_req(i, a, b, c);
        eg = model_grant(bus.REQ_VALID, rr_m);
        wait_accept(40, g, rdy, ok);
        n_cmp++; if (!ok || g != eg) begin n_err++; $display("FAIL %s_grant: got %0d want %0d", nm, g, eg); end
        n_cmp++; if (rdy !== 4'(1 << eg)) begin n_err++; $display("FAIL %s_ready: got %b want %b", nm, rdy, 4'(1 << eg)); end
        sb.push_back(model_result(eg));
        rr_m = (eg + 1) % NREQ;
        bus.REQ_VALID[i] = 1'b0;
        wait_rsp(40, cyc, ok, leak);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL %s_timeout: got no RSP_VALID want RSP_VALID", nm); end
        if (check_lat) begin
            n_cmp++; if (cyc != 17) begin n_err++; $display("FAIL %s_latency: got %0d want 17", nm, cyc); end
        end
        e = sb.pop_front();
        n_cmp++; if (bus.RSP_ID !== e.id) begin n_err++; $display("FAIL %s_id: got %0d want %0d", nm, bus.RSP_ID, e.id); end
        n_cmp++; if (bus.RSP_SUM !== e.sum) begin n_err++; $display("FAIL %s_sum: got %h want %h", nm, bus.RSP_SUM, e.sum); end
        n_cmp++; if (bus.RSP_COUT !== e.cout) begin n_err++; $display("FAIL %s_cout: got %b want %b", nm, bus.RSP_COUT, e.cout); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bus.RSP_READY = 1'b1;
        run_single("basic", 0, 16'h1234, 16'h0001, 1'b0, 1);
        @(negedge clk);
        n_cmp++; if (bus.RSP_VALID !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_release: got valid=%b busy=%b want 0 0", bus.RSP_VALID, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_carry();
        run_single("overflow", 2, 16'hFFFF, 16'h0001, 1'b0, 1);
        run_single("cin_only", 2, 16'h0000, 16'h0000, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        int g, cyc, eg; logic [3:0] rdy; bit ok, leak; exp_t e;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 16'(i), 16'h0010, 1'b0);
        for (int j = 0; j < 5; j++) begin
            eg = model_grant(bus.REQ_VALID, rr_m);
            wait_accept(40, g, rdy, ok);
            n_cmp++; if (!ok || g != eg) begin n_err++; $display("FAIL rr_grant%0d: got %0d want %0d", j, g, eg); end
            sb.push_back(model_result(eg));
            rr_m = (eg + 1) % NREQ;
            if (j == 4) bus.REQ_VALID = '0;
            wait_rsp(40, cyc, ok, leak);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_timeout%0d: got no RSP_VALID want RSP_VALID", j); end
            n_cmp++; if (leak) begin n_err++; $display("FAIL rr_ready_busy%0d: got REQ_READY while busy want 0000", j); end
            e = sb.pop_front();
            n_cmp++; if (bus.RSP_ID !== e.id || bus.RSP_SUM !== e.sum || bus.RSP_COUT !== e.cout)
                begin n_err++; $display("FAIL rr_rsp%0d: got id=%0d sum=%h cout=%b want id=%0d sum=%h cout=%b", j, bus.RSP_ID, bus.RSP_SUM, bus.RSP_COUT, e.id, e.sum, e.cout); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        int g, cyc, eg; logic [3:0] rdy; bit ok, leak; exp_t e;
        bus.RSP_READY = 1'b0;
        set_req(3, 16'hAAAA, 16'h5555, 1'b1);
        eg = model_grant(bus.REQ_VALID, rr_m);
        wait_accept(40, g, rdy, ok);
        n_cmp++; if (!ok || g != eg) begin n_err++; $display("FAIL stall_grant: got %0d want %0d", g, eg); end
        sb.push_back(model_result(eg));
        rr_m = (eg + 1) % NREQ;
        bus.REQ_VALID[3] = 1'b0;
        set_req(0, 16'h0001, 16'h0002, 1'b0);  // competing request during the stall
        wait_rsp(40, cyc, ok, leak);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_timeout: got no RSP_VALID want RSP_VALID"); end
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            n_cmp++; if (bus.RSP_VALID !== 1'b1 || bus.RSP_SUM !== e.sum || bus.RSP_COUT !== e.cout || bus.RSP_ID !== e.id)
                begin n_err++; $display("FAIL stall_hold%0d: got v=%b sum=%h cout=%b want v=1 sum=%h cout=%b", k, bus.RSP_VALID, bus.RSP_SUM, bus.RSP_COUT, e.sum, e.cout); end
            n_cmp++; if (bus.REQ_READY !== 4'b0000) begin n_err++; $display("FAIL stall_ready%0d: got %b want 0000", k, bus.REQ_READY); end
            @(posedge clk); #1;
        end
        bus.REQ_VALID[0] = 1'b0;  // withdrawn before grant
        bus.RSP_READY = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.RSP_VALID !== 1'b1) begin n_err++; $display("FAIL stall_rise: got %b want 1", bus.RSP_VALID); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (bus.RSP_VALID !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL stall_done: got v=%b busy=%b want 0 0", bus.RSP_VALID, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int g, cyc, eg; logic [3:0] rdy; bit ok, leak, bad;
        set_req(1, 16'h0F0F, 16'h1111, 1'b0);
        eg = model_grant(bus.REQ_VALID, rr_m);
        wait_accept(40, g, rdy, ok);
        n_cmp++; if (!ok || g != 1) begin n_err++; $display("FAIL abort_grant: got %0d want 1 (model %0d)", g, eg); end
        bus.REQ_VALID[1] = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.RSP_VALID !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_in_reset: got v=%b busy=%b want 0 0", bus.RSP_VALID, busy); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        rr_m = 0;
        bad = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (bus.RSP_VALID !== 1'b0 || busy !== 1'b0) bad = 1;
            @(posedge clk); #1;
        end
        n_cmp++; if (bad) begin n_err++; $display("FAIL abort_no_rsp: got RSP_VALID/BUSY high after abort want low"); end
        // req3 and req0 both valid: pointer restarted at 0 so req0 wins.
        set_req(3, 16'h0100, 16'h0200, 1'b0);
        run_single("after_abort_r0", 0, 16'h7FFF, 16'h0001, 1'b0, 0);
        run_single("after_abort_r3", 3, 16'h0100, 16'h0200, 1'b0, 0);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_empty: got %0d left want 0", sb.size()); end
    endtask

    initial begin
        rst = 1'b1;
        bus.REQ_VALID = '0;
        bus.REQ_A     = '0;
        bus.REQ_B     = '0;
        bus.REQ_CIN   = '0;
        bus.RSP_READY = 1'b1;
        for (int i = 0; i < NREQ; i++) begin a_m[i] = '0; b_m[i] = '0; c_m[i] = 1'b0; end
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_stall();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
